// File: rtl/link_vc_receiver_pkg.sv
// Shared link constants, flit field positions and type encodings for the link VC receiver.
// The optional packet-order checker in link_vc_receiver is enabled by LINK_RX_PROTOCOL_CHECK_EN.
package link_vc_receiver_pkg;

    localparam int N_OF_VN     = 2;
    localparam int N_OF_VC     = 2;
    localparam int N_TOT_OF_VC = N_OF_VN * N_OF_VC;
    localparam int VC_ID_WIDTH = (N_TOT_OF_VC > 1) ? $clog2(N_TOT_OF_VC) : 1;
    localparam int FLIT_WIDTH  = 16;
    localparam int VC_DEPTH    = 4;

    // Type field sits in the two MSBs, VC id immediately below it.
    localparam int TYPE_MSB = FLIT_WIDTH - 1;
    localparam int TYPE_LSB = FLIT_WIDTH - 2;
    localparam int VC_MSB   = FLIT_WIDTH - 3;
    localparam int VC_LSB   = FLIT_WIDTH - 2 - VC_ID_WIDTH;

    typedef enum logic [1:0] {
        FLIT_HEAD      = 2'b00,
        FLIT_BODY      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        PROTO_IDLE = 1'b0,
        PROTO_BUSY = 1'b1
    } proto_state_e;

    function automatic logic is_last(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/link_vc_fifo.sv
// Single-VC circular flit buffer; pointers carry one extra wrap bit so full and empty differ.
module link_vc_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the head slot in the same edge, so a full buffer may still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/link_vc_receiver.sv
// Receive side of the credit-based link: per-VC buffers, credit/free return pulses, error flags.
// Optional packet-order checking is compiled in with LINK_RX_PROTOCOL_CHECK_EN.
module link_vc_receiver
    import link_vc_receiver_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  in_link_i,
    input  logic                   is_valid_i,
    output logic [N_TOT_OF_VC-1:0] credit_signal_o,
    output logic [N_TOT_OF_VC-1:0] free_signal_o,
    output logic [N_TOT_OF_VC-1:0] vc_nonempty_o,
    input  logic [VC_ID_WIDTH-1:0] rd_vc_i,
    input  logic                   rd_en_i,
    output logic [FLIT_WIDTH-1:0]  flit_o,
    output logic                   overflow_o,
    output logic                   proto_err_o
);

    // Handshake: is_valid_i has no back-pressure; a flit is taken on every valid cycle or
    // dropped with overflow_o. rd_en_i pops only when the selected VC is non-empty.

    localparam logic [VC_ID_WIDTH:0] VC_LIMIT = (VC_ID_WIDTH+1)'(N_TOT_OF_VC);

    logic [VC_ID_WIDTH-1:0] wr_vc;
    logic                   wr_vc_ok, rd_vc_ok, pop_ok, drop;
    logic [N_TOT_OF_VC-1:0] full_w, empty_w;
    logic [FLIT_WIDTH-1:0]  head_w [N_TOT_OF_VC];
    logic [N_TOT_OF_VC-1:0] credit_d, free_d, credit_q, free_q;
    logic                   overflow_q;

    assign wr_vc    = in_link_i[VC_MSB:VC_LSB];
    assign wr_vc_ok = ({1'b0, wr_vc} < VC_LIMIT);
    assign rd_vc_ok = ({1'b0, rd_vc_i} < VC_LIMIT);

    assign vc_nonempty_o = ~empty_w;
    assign pop_ok        = rd_en_i && rd_vc_ok && vc_nonempty_o[rd_vc_i];

    // A push to a full VC survives only if that same VC is popped this cycle.
    assign drop = is_valid_i &&
                  (!wr_vc_ok || (full_w[wr_vc] && !(pop_ok && (rd_vc_i == wr_vc))));

    for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
        link_vc_fifo #(
            .WIDTH (FLIT_WIDTH),
            .DEPTH (VC_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (is_valid_i && wr_vc_ok && (wr_vc == VC_ID_WIDTH'(v))),
            .pop   (pop_ok && (rd_vc_i == VC_ID_WIDTH'(v))),
            .din   (in_link_i),
            .full  (full_w[v]),
            .empty (empty_w[v]),
            .head  (head_w[v])
        );
    end

    assign flit_o = rd_vc_ok ? head_w[rd_vc_i] : '0;

    always_comb begin
        credit_d = '0;
        free_d   = '0;
        if (pop_ok) begin
            credit_d[rd_vc_i] = 1'b1;
            free_d[rd_vc_i]   = is_last(flit_type_e'(flit_o[TYPE_MSB:TYPE_LSB]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q   <= '0;
            free_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
            free_q   <= free_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign credit_signal_o = credit_q;
    assign free_signal_o   = free_q;
    assign overflow_o      = overflow_q;

`ifdef LINK_RX_PROTOCOL_CHECK_EN
    flit_type_e   wr_type;
    logic         push_acc, proto_viol, proto_err_q;
    proto_state_e st_q [N_TOT_OF_VC];
    proto_state_e st_d [N_TOT_OF_VC];

    assign wr_type  = flit_type_e'(in_link_i[TYPE_MSB:TYPE_LSB]);
    assign push_acc = is_valid_i && !drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TOT_OF_VC; i++) st_q[i] <= PROTO_IDLE;
            proto_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_TOT_OF_VC; i++) st_q[i] <= st_d[i];
            if (proto_viol) proto_err_q <= 1'b1;
        end
    end

    // Illegal types are still stored; only the sticky flag records them, state holds.
    always_comb begin
        for (int i = 0; i < N_TOT_OF_VC; i++) st_d[i] = st_q[i];
        proto_viol = 1'b0;
        if (push_acc) begin
            case (st_q[wr_vc])
                PROTO_IDLE: begin
                    if (wr_type == FLIT_HEAD)           st_d[wr_vc] = PROTO_BUSY;
                    else if (wr_type != FLIT_HEAD_TAIL) proto_viol  = 1'b1;
                end
                PROTO_BUSY: begin
                    if (wr_type == FLIT_TAIL)           st_d[wr_vc] = PROTO_IDLE;
                    else if (wr_type != FLIT_BODY)      proto_viol  = 1'b1;
                end
            endcase
        end
    end

    assign proto_err_o = proto_err_q;
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_link_vc_receiver.sv
// Directed self-checking bench for link_vc_receiver (4 VCs, depth 4).
module tb_link_vc_receiver;
    import link_vc_receiver_pkg::*;

    localparam int NV = N_TOT_OF_VC;
    localparam int FW = FLIT_WIDTH;
    localparam int PW = FW - 2 - VC_ID_WIDTH;
`ifdef LINK_RX_PROTOCOL_CHECK_EN
    localparam logic PROTO_EXP = 1'b1;
`else
    localparam logic PROTO_EXP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [FW-1:0]          in_link_i = '0;
    logic                   is_valid_i = 1'b0;
    logic [NV-1:0]          credit_signal_o, free_signal_o, vc_nonempty_o;
    logic [VC_ID_WIDTH-1:0] rd_vc_i = '0;
    logic                   rd_en_i = 1'b0;
    logic [FW-1:0]          flit_o;
    logic                   overflow_o, proto_err_o;

    int n_checks = 0;
    int n_errors = 0;

    link_vc_receiver dut (
        .clk             (clk),
        .rst             (rst),
        .in_link_i       (in_link_i),
        .is_valid_i      (is_valid_i),
        .credit_signal_o (credit_signal_o),
        .free_signal_o   (free_signal_o),
        .vc_nonempty_o   (vc_nonempty_o),
        .rd_vc_i         (rd_vc_i),
        .rd_en_i         (rd_en_i),
        .flit_o          (flit_o),
        .overflow_o      (overflow_o),
        .proto_err_o     (proto_err_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input flit_type_e t, input int vc, input int pl);
        return {t, VC_ID_WIDTH'(vc), PW'(pl)};
    endfunction

    // drivers
    task automatic push(input logic [FW-1:0] f);
        in_link_i  = f;
        is_valid_i = 1'b1;
        tick();
        is_valid_i = 1'b0;
    endtask

    task automatic pop(input int vc);
        rd_vc_i = VC_ID_WIDTH'(vc);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
    endtask

    initial begin
        tick();
        check("reset_nonempty", 32'(vc_nonempty_o), 0);
        check("reset_credit", 32'(credit_signal_o), 0);
        check("reset_free", 32'(free_signal_o), 0);
        check("reset_overflow", 32'(overflow_o), 0);
        check("reset_proto", 32'(proto_err_o), 0);
        rst = 1'b0;
        tick();

        // single packet on VC2
        push(mk(FLIT_HEAD, 2, 'h101));
        push(mk(FLIT_BODY, 2, 'h102));
        push(mk(FLIT_TAIL, 2, 'h103));
        check("pkt_nonempty", 32'(vc_nonempty_o), 32'h4);
        rd_vc_i = 2;
        check("pkt_head", 32'(flit_o), 32'(mk(FLIT_HEAD, 2, 'h101)));
        pop(2);
        check("pkt_credit0", 32'(credit_signal_o), 32'h4);
        check("pkt_free0", 32'(free_signal_o), 0);
        check("pkt_body", 32'(flit_o), 32'(mk(FLIT_BODY, 2, 'h102)));
        pop(2);
        check("pkt_credit1", 32'(credit_signal_o), 32'h4);
        check("pkt_free1", 32'(free_signal_o), 0);
        check("pkt_tail", 32'(flit_o), 32'(mk(FLIT_TAIL, 2, 'h103)));
        pop(2);
        check("pkt_credit2", 32'(credit_signal_o), 32'h4);
        check("pkt_free2", 32'(free_signal_o), 32'h4);
        check("pkt_drained", 32'(vc_nonempty_o), 0);
        tick();
        check("pkt_credit_end", 32'(credit_signal_o), 0);
        check("pkt_proto", 32'(proto_err_o), 0);

        // full VC0, fifth flit dropped
        push(mk(FLIT_HEAD, 0, 'h10));
        for (int i = 1; i < 4; i++) push(mk(FLIT_BODY, 0, 'h10 + i));
        check("full_no_ovf", 32'(overflow_o), 0);
        push(mk(FLIT_TAIL, 0, 'h14));
        check("full_ovf", 32'(overflow_o), 1);
        rd_vc_i = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_data%0d", i), 32'(flit_o[PW-1:0]), 'h10 + i);
            pop(0);
            check($sformatf("full_credit%0d", i), 32'(credit_signal_o), 32'h1);
        end
        check("full_drained", 32'(vc_nonempty_o), 0);
        do_reset();
        check("full_ovf_cleared", 32'(overflow_o), 0);

        // full VC0 with same-cycle pop
        push(mk(FLIT_HEAD, 0, 'h20));
        for (int i = 1; i < 4; i++) push(mk(FLIT_BODY, 0, 'h20 + i));
        in_link_i  = mk(FLIT_TAIL, 0, 'h24);
        is_valid_i = 1'b1;
        rd_vc_i    = 0;
        rd_en_i    = 1'b1;
        tick();
        is_valid_i = 1'b0;
        rd_en_i    = 1'b0;
        check("fpp_no_ovf", 32'(overflow_o), 0);
        check("fpp_credit", 32'(credit_signal_o), 32'h1);
        check("fpp_free", 32'(free_signal_o), 0);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("fpp_data%0d", i), 32'(flit_o[PW-1:0]), 'h20 + i);
            pop(0);
        end
        check("fpp_free_tail", 32'(free_signal_o), 32'h1);
        check("fpp_drained", 32'(vc_nonempty_o), 0);
        check("fpp_proto", 32'(proto_err_o), 0);

        // interleave: push VC3 while popping VC1
        for (int i = 0; i < 4; i++) push(mk(FLIT_HEAD_TAIL, 1, 'h30 + i));
        for (int i = 0; i < 4; i++) begin
            rd_vc_i = 1;
            check($sformatf("il_pop%0d", i), 32'(flit_o), 32'(mk(FLIT_HEAD_TAIL, 1, 'h30 + i)));
            in_link_i  = mk(FLIT_HEAD_TAIL, 3, 'h40 + i);
            is_valid_i = 1'b1;
            rd_en_i    = 1'b1;
            tick();
            is_valid_i = 1'b0;
            rd_en_i    = 1'b0;
            check($sformatf("il_credit%0d", i), 32'(credit_signal_o), 32'h2);
            check($sformatf("il_free%0d", i), 32'(free_signal_o), 32'h2);
        end
        check("il_nonempty", 32'(vc_nonempty_o), 32'h8);
        check("il_no_ovf", 32'(overflow_o), 0);
        rd_vc_i = 3;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("il_vc3_%0d", i), 32'(flit_o[PW-1:0]), 'h40 + i);
            pop(3);
            check($sformatf("il_vc3_credit%0d", i), 32'(credit_signal_o), 32'h8);
        end

        // protocol: body to idle VC0
        do_reset();
        push(mk(FLIT_BODY, 0, 'h55));
        check("proto_err", 32'(proto_err_o), 32'(PROTO_EXP));
        check("proto_stored", 32'(vc_nonempty_o), 32'h1);
        rd_vc_i = 0;
        check("proto_flit", 32'(flit_o), 32'(mk(FLIT_BODY, 0, 'h55)));
        pop(0);
        check("proto_credit", 32'(credit_signal_o), 32'h1);

        // empty pop on VC2, then normal traffic
        pop(2);
        check("epop_credit", 32'(credit_signal_o), 0);
        check("epop_free", 32'(free_signal_o), 0);
        check("epop_nonempty", 32'(vc_nonempty_o), 0);
        push(mk(FLIT_HEAD_TAIL, 2, 'h66));
        check("epop_push", 32'(vc_nonempty_o), 32'h4);
        rd_vc_i = 2;
        check("epop_flit", 32'(flit_o), 32'(mk(FLIT_HEAD_TAIL, 2, 'h66)));
        pop(2);
        check("epop_credit2", 32'(credit_signal_o), 32'h4);
        check("epop_free2", 32'(free_signal_o), 32'h4);
        check("epop_drained", 32'(vc_nonempty_o), 0);

        // asynchronous reset with VC1 mid-packet
        push(mk(FLIT_HEAD, 1, 'h70));
        push(mk(FLIT_BODY, 1, 'h71));
        push(mk(FLIT_BODY, 1, 'h72));
        push(mk(FLIT_BODY, 3, 'h73));
        check("mid_ovf_state", 32'(overflow_o), 0);
        pop(1);
        check("mid_credit", 32'(credit_signal_o), 32'h2);
        rst = 1'b1;
        #1;
        check("async_credit", 32'(credit_signal_o), 0);
        check("async_nonempty", 32'(vc_nonempty_o), 0);
        check("async_proto", 32'(proto_err_o), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_nonempty", 32'(vc_nonempty_o), 0);
        check("post_credit", 32'(credit_signal_o), 0);
        check("post_free", 32'(free_signal_o), 0);
        tick();
        check("post_credit2", 32'(credit_signal_o), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
